// File: rtl/ram_bist_ctrl.sv
// ============================================================================
// ram_bist_ctrl
// ----------------------------------------------------------------------------
// Built-in self-test controller for a single-port RAM. On start it writes
// pat(k) = 2*k + SEED to addresses 0..DEPTH-1 back to back. It then reads the
// same addresses back and compares every returned word against the pattern.
// At the end it pulses done, registers pass and leaves the saturating
// mismatch count on err_count.
//
// Parameters
//   AW      RAM address width
//   DW      RAM data width
//   DEPTH   number of words tested from address 0 (1..2**AW)
//   RD_LAT  RAM read latency in cycles, 0 (combinational) or 1 (registered)
//   SEED    additive offset of the test pattern
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         one-cycle request, only honoured while idle
//   busy          high while writing, reading or draining
//   done          one-cycle pulse when the test has finished
//   pass          1 when the last finished run saw no mismatch
//   err_count     mismatch count, saturating at 16'hFFFF
//   mem_address   RAM address
//   mem_data_in   RAM write data
//   mem_write     RAM write enable (only ever high together with mem_select)
//   mem_select    RAM select
//   mem_data_out  RAM read data
//
// Optional build macro RAM_BIST_ERRLOG_EN
//   Adds err_addr, err_exp and err_got. These hold the address, expected word
//   and returned word of the first mismatch of a run. They clear on reset and
//   on an accepted start.
// ============================================================================
module ram_bist_ctrl #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1,
    parameter int SEED   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   err_count,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    output logic          mem_write,
    output logic          mem_select,
    input  logic [DW-1:0] mem_data_out
`ifdef RAM_BIST_ERRLOG_EN
    ,
    output logic [AW-1:0] err_addr,
    output logic [DW-1:0] err_exp,
    output logic [DW-1:0] err_got
`endif
);

    // The word counter has one spare bit so that DEPTH = 2**AW reaches its
    // last index without the address wrapping back to 0.
    localparam int            CW     = AW + 1;
    localparam logic [CW-1:0] K_LAST = CW'(DEPTH - 1);
    localparam logic [DW-1:0] SEED_V = DW'(SEED);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic [15:0]   err_count_q, err_count_d;
    logic          pass_q, pass_d;

    logic [DW-1:0] k_dw;
    logic [DW-1:0] pat_cur;
    logic          rd_issue;
    logic          start_acc;

    logic          cmp_vld;
    logic [DW-1:0] cmp_exp;
    logic          mismatch;

    // The pattern is computed in DW bits, so the sum wraps modulo 2**DW.
    always_comb begin
        k_dw    = DW'(k_q);
        pat_cur = (k_dw << 1) + SEED_V;
    end

    assign rd_issue  = (state_q == ST_READ);
    assign start_acc = (state_q == ST_IDLE) && start;

    // The read delay line carries each expected word alongside the read so
    // that it arrives at the comparator together with the RAM data.
`ifdef RAM_BIST_ERRLOG_EN
    logic [AW-1:0] cmp_addr;
`endif

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign cmp_vld = rd_issue;
            assign cmp_exp = pat_cur;
`ifdef RAM_BIST_ERRLOG_EN
            assign cmp_addr = k_q[AW-1:0];
`endif
        end else begin : g_lat1
            logic          vld_q, vld_d;
            logic [DW-1:0] exp_q, exp_d;
`ifdef RAM_BIST_ERRLOG_EN
            logic [AW-1:0] addr_q, addr_d;
`endif

            // Capture what was asked for this cycle; idle cycles load zeros.
            always_comb begin
                vld_d = rd_issue;
                exp_d = rd_issue ? pat_cur : '0;
`ifdef RAM_BIST_ERRLOG_EN
                addr_d = rd_issue ? k_q[AW-1:0] : '0;
`endif
            end

            // Delay line register, one stage for a registered RAM.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    exp_q <= '0;
`ifdef RAM_BIST_ERRLOG_EN
                    addr_q <= '0;
`endif
                end else begin
                    vld_q <= vld_d;
                    exp_q <= exp_d;
`ifdef RAM_BIST_ERRLOG_EN
                    addr_q <= addr_d;
`endif
                end
            end

            assign cmp_vld = vld_q;
            assign cmp_exp = exp_q;
`ifdef RAM_BIST_ERRLOG_EN
            assign cmp_addr = addr_q;
`endif
        end
    endgenerate

    assign mismatch = cmp_vld && (mem_data_out != cmp_exp);

    // Next-state, counters and RAM drive. The mismatch increment comes before
    // the state case so that clearing on an accepted start wins.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        err_count_d = err_count_q;
        pass_d      = pass_q;
        busy        = 1'b0;
        done        = 1'b0;
        mem_select  = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_data_in = '0;

        if (mismatch && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_WRITE;
                    k_d         = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                end
            end
            ST_WRITE: begin
                busy        = 1'b1;
                mem_select  = 1'b1;
                mem_write   = 1'b1;
                mem_address = k_q[AW-1:0];
                mem_data_in = pat_cur;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_READ;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            ST_READ: begin
                busy        = 1'b1;
                mem_select  = 1'b1;
                mem_address = k_q[AW-1:0];
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = (RD_LAT == 0) ? ST_DONE : ST_DRAIN;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The last compare lands on the cycle that enters DONE. Therefore pass
        // is judged on the final count, so it is already valid while done is
        // high.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            pass_d = (err_count_d == 16'd0);
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            err_count_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
        end
    end

    assign err_count = err_count_q;
    assign pass      = pass_q;

`ifdef RAM_BIST_ERRLOG_EN
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic [DW-1:0] err_exp_q, err_exp_d;
    logic [DW-1:0] err_got_q, err_got_d;

    // A zero error count means no mismatch has been seen yet in this run.
    // That is exactly when the first mismatch must be logged.
    always_comb begin
        err_addr_d = err_addr_q;
        err_exp_d  = err_exp_q;
        err_got_d  = err_got_q;
        if (start_acc) begin
            err_addr_d = '0;
            err_exp_d  = '0;
            err_got_d  = '0;
        end else if (mismatch && (err_count_q == 16'd0)) begin
            err_addr_d = cmp_addr;
            err_exp_d  = cmp_exp;
            err_got_d  = mem_data_out;
        end
    end

    // First-mismatch log registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
        end else begin
            err_addr_q <= err_addr_d;
            err_exp_q  <= err_exp_d;
            err_got_q  <= err_got_d;
        end
    end

    assign err_addr = err_addr_q;
    assign err_exp  = err_exp_q;
    assign err_got  = err_got_q;
`else
    // start_acc only feeds the error log; keep it referenced when it is absent.
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_ram_bist_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// tb_ram_bist_ctrl
// ----------------------------------------------------------------------------
// Three controller instances:
//   dut    defaults (DEPTH 32, registered RAM) with random bit faults
//   dut_c  RD_LAT 0, DEPTH 4, SEED 7, combinational RAM
//   dut_w  AW 3, DEPTH 8 = 2**AW, RAM whose read data is stuck at 0
// Expected accesses and results are queued when a start is issued. Monitors
// pop and compare them whenever the controller drives the RAM or pulses done.
// Build with RAM_BIST_ERRLOG_EN defined to also check the error log ports.
// ============================================================================
module tb_ram_bist_ctrl;

    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int DEPTH  = 32;
    localparam int RD_LAT = 1;
    localparam int SEED   = 0;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_rec_t;

    typedef struct {
        int            cyc;
        logic [15:0]   errc;
        logic          pass;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] eexp;
        logic [DW-1:0] egot;
    } done_rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int total = 0;
    int bad   = 0;

    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start_c = 1'b0;
    logic start_w = 1'b0;

    // ---------------- main instance ----------------
    logic          busy, done, pass, mem_write, mem_select;
    logic [15:0]   err_count;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in, ram_rdata;
`ifdef RAM_BIST_ERRLOG_EN
    logic [AW-1:0] err_addr;
    logic [DW-1:0] err_exp, err_got;
`endif

    ram_bist_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write(mem_write), .mem_select(mem_select), .mem_data_out(ram_rdata)
`ifdef RAM_BIST_ERRLOG_EN
        , .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got)
`endif
    );

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] or_mask [0:(1<<AW)-1];
    logic [DW-1:0] and_mask[0:(1<<AW)-1];

    // Registered single-port RAM with per-word read faults.
    always @(posedge clk) begin
        if (mem_select) begin
            if (mem_write) ram[mem_address] <= mem_data_in;
            else ram_rdata <= (ram[mem_address] | or_mask[mem_address]) & and_mask[mem_address];
        end
    end

    // ---------------- combinational-RAM instance ----------------
    logic          busy_c, done_c, pass_c, mem_write_c, mem_select_c;
    logic [15:0]   err_count_c;
    logic [AW-1:0] mem_address_c;
    logic [DW-1:0] mem_data_in_c, ram_rdata_c;
`ifdef RAM_BIST_ERRLOG_EN
    logic [AW-1:0] err_addr_c;
    logic [DW-1:0] err_exp_c, err_got_c;
`endif

    ram_bist_ctrl #(.AW(AW), .DW(DW), .DEPTH(4), .RD_LAT(0), .SEED(7)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_count_c), .mem_address(mem_address_c), .mem_data_in(mem_data_in_c),
        .mem_write(mem_write_c), .mem_select(mem_select_c), .mem_data_out(ram_rdata_c)
`ifdef RAM_BIST_ERRLOG_EN
        , .err_addr(err_addr_c), .err_exp(err_exp_c), .err_got(err_got_c)
`endif
    );

    logic [DW-1:0] ram_c [0:(1<<AW)-1];
    logic [DW-1:0] or_c  [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_select_c && mem_write_c) ram_c[mem_address_c] <= mem_data_in_c;
    end
    assign ram_rdata_c = ram_c[mem_address_c] | or_c[mem_address_c];

    // ---------------- full-address-space instance ----------------
    logic          busy_w, done_w, pass_w, mem_write_w, mem_select_w;
    logic [15:0]   err_count_w;
    logic [2:0]    mem_address_w;
    logic [DW-1:0] mem_data_in_w, ram_rdata_w;
`ifdef RAM_BIST_ERRLOG_EN
    logic [2:0]    err_addr_w;
    logic [DW-1:0] err_exp_w, err_got_w;
`endif
    assign ram_rdata_w = '0;

    ram_bist_ctrl #(.AW(3), .DW(DW), .DEPTH(8), .RD_LAT(1), .SEED(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .busy(busy_w), .done(done_w), .pass(pass_w),
        .err_count(err_count_w), .mem_address(mem_address_w), .mem_data_in(mem_data_in_w),
        .mem_write(mem_write_w), .mem_select(mem_select_w), .mem_data_out(ram_rdata_w)
`ifdef RAM_BIST_ERRLOG_EN
        , .err_addr(err_addr_w), .err_exp(err_exp_w), .err_got(err_got_w)
`endif
    );

    // ---------------- scoreboard ----------------
    acc_rec_t  acc_q[$],  acc_q_c[$],  acc_q_w[$];
    done_rec_t done_q[$], done_q_c[$], done_q_w[$];

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h required=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [63:0] got);
        total++;
        bad++;
        $display("[TB] FAIL %s got=%0h required=none (t=%0t)", name, got, $time);
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    acc_rec_t  m_acc, m_acc_c, m_acc_w;
    done_rec_t m_done, m_done_c, m_done_w;

    // Main instance monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_write) checkOutput("write_implies_select", 64'(mem_select), 64'd1);
            if (mem_select) begin
                if (acc_q.size() == 0) reportUnexpected("unexpected_access_addr", 64'(mem_address));
                else begin
                    m_acc = acc_q.pop_front();
                    checkOutput("access_write", 64'(mem_write), 64'(m_acc.wr));
                    checkOutput("access_addr", 64'(mem_address), 64'(m_acc.addr));
                    checkOutput("access_data_in", 64'(mem_data_in), 64'(m_acc.data));
                    checkOutput("access_busy", 64'(busy), 64'd1);
                end
            end
            if (done) begin
                if (done_q.size() == 0) reportUnexpected("unexpected_done_cycle", 64'(cyc));
                else begin
                    m_done = done_q.pop_front();
                    checkOutput("done_latency_cycle", 64'(cyc), 64'(m_done.cyc));
                    checkOutput("done_err_count", 64'(err_count), 64'(m_done.errc));
                    checkOutput("done_pass", 64'(pass), 64'(m_done.pass));
                    checkOutput("done_busy_low", 64'(busy), 64'd0);
`ifdef RAM_BIST_ERRLOG_EN
                    checkOutput("done_err_addr", 64'(err_addr), 64'(m_done.eaddr));
                    checkOutput("done_err_exp", 64'(err_exp), 64'(m_done.eexp));
                    checkOutput("done_err_got", 64'(err_got), 64'(m_done.egot));
`endif
                end
            end
        end
    end

    // Combinational-RAM instance monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_write_c) checkOutput("c_write_implies_select", 64'(mem_select_c), 64'd1);
            if (mem_select_c) begin
                if (acc_q_c.size() == 0) reportUnexpected("c_unexpected_access_addr", 64'(mem_address_c));
                else begin
                    m_acc_c = acc_q_c.pop_front();
                    checkOutput("c_access_write", 64'(mem_write_c), 64'(m_acc_c.wr));
                    checkOutput("c_access_addr", 64'(mem_address_c), 64'(m_acc_c.addr));
                    checkOutput("c_access_data_in", 64'(mem_data_in_c), 64'(m_acc_c.data));
                end
            end
            if (done_c) begin
                if (done_q_c.size() == 0) reportUnexpected("c_unexpected_done_cycle", 64'(cyc));
                else begin
                    m_done_c = done_q_c.pop_front();
                    checkOutput("c_done_latency_cycle", 64'(cyc), 64'(m_done_c.cyc));
                    checkOutput("c_done_err_count", 64'(err_count_c), 64'(m_done_c.errc));
                    checkOutput("c_done_pass", 64'(pass_c), 64'(m_done_c.pass));
`ifdef RAM_BIST_ERRLOG_EN
                    checkOutput("c_done_err_addr", 64'(err_addr_c), 64'(m_done_c.eaddr));
                    checkOutput("c_done_err_got", 64'(err_got_c), 64'(m_done_c.egot));
`endif
                end
            end
        end
    end

    // Full-address-space instance monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_select_w) begin
                if (acc_q_w.size() == 0) reportUnexpected("w_unexpected_access_addr", 64'(mem_address_w));
                else begin
                    m_acc_w = acc_q_w.pop_front();
                    checkOutput("w_access_write", 64'(mem_write_w), 64'(m_acc_w.wr));
                    checkOutput("w_access_addr", 64'(mem_address_w), 64'(m_acc_w.addr));
                    checkOutput("w_access_data_in", 64'(mem_data_in_w), 64'(m_acc_w.data));
                end
            end
            if (done_w) begin
                if (done_q_w.size() == 0) reportUnexpected("w_unexpected_done_cycle", 64'(cyc));
                else begin
                    m_done_w = done_q_w.pop_front();
                    checkOutput("w_done_latency_cycle", 64'(cyc), 64'(m_done_w.cyc));
                    checkOutput("w_done_err_count", 64'(err_count_w), 64'(m_done_w.errc));
                    checkOutput("w_done_pass", 64'(pass_w), 64'(m_done_w.pass));
`ifdef RAM_BIST_ERRLOG_EN
                    checkOutput("w_done_err_addr", 64'(err_addr_w), 64'(m_done_w.eaddr));
                    checkOutput("w_done_err_got", 64'(err_got_w), 64'(m_done_w.egot));
`endif
                end
            end
        end
    end

    // Reference model: the RAM stores the pattern and returns it through the
    // fault masks, so every word whose faulty read differs from pat(k) counts.
    function automatic done_rec_t modelRun(input int depth, input int seed, input int base_cyc,
                                           input int rd_lat, input bit stuck0, input bit comb);
        done_rec_t     d;
        logic [DW-1:0] p, g;
        d.cyc   = base_cyc + 2 * depth + rd_lat + 1;
        d.errc  = 16'd0;
        d.eaddr = '0;
        d.eexp  = '0;
        d.egot  = '0;
        for (int k = 0; k < depth; k++) begin
            p = DW'(2 * k + seed);
            if (stuck0) g = '0;
            else if (comb) g = p | or_c[k];
            else g = (p | or_mask[k]) & and_mask[k];
            if (g != p) begin
                if (d.errc == 16'd0) begin
                    d.eaddr = AW'(k);
                    d.eexp  = p;
                    d.egot  = g;
                end
                d.errc = d.errc + 16'd1;
            end
        end
        d.pass = (d.errc == 16'd0);
        return d;
    endfunction

    task automatic pushAccesses(input int depth, input int seed, input int which);
        acc_rec_t r;
        for (int pass_i = 0; pass_i < 2; pass_i++) begin
            for (int k = 0; k < depth; k++) begin
                r.wr   = (pass_i == 0);
                r.addr = AW'(k);
                r.data = (pass_i == 0) ? DW'(2 * k + seed) : '0;
                if (which == 0) acc_q.push_back(r);
                else if (which == 1) acc_q_c.push_back(r);
                else acc_q_w.push_back(r);
            end
        end
    endtask

    task automatic flushQueues();
        acc_q.delete();
        done_q.delete();
        acc_q_c.delete();
        done_q_c.delete();
        acc_q_w.delete();
        done_q_w.delete();
    endtask

    // One run on the main instance. Optionally it injects random read faults
    // or the word-5 bit-0 fault. Optionally it pokes start while busy and in DONE.
    task automatic applyStimulus(input int n_faults, input bit word5_fault, input bit poke);
        done_rec_t d;
        int        base, mid, guard;
        int        a, b;
        for (int k = 0; k < DEPTH; k++) begin
            or_mask[k]  = '0;
            and_mask[k] = '1;
        end
        if (word5_fault) or_mask[5][0] = 1'b1;
        for (int i = 0; i < n_faults; i++) begin
            a = $urandom_range(0, DEPTH - 1);
            b = $urandom_range(0, DW - 1);
            if ($urandom_range(0, 1) == 1) or_mask[a][b] = 1'b1;
            else and_mask[a][b] = 1'b0;
        end
        waitCycle();
        base = cyc;
        d = modelRun(DEPTH, SEED, base, RD_LAT, 1'b0, 1'b0);
        pushAccesses(DEPTH, SEED, 0);
        done_q.push_back(d);
        start = 1'b1;
        waitCycle();
        start = 1'b0;
        if (poke) begin
            mid = base + $urandom_range(2, 2 * DEPTH);
            while (cyc < mid) waitCycle();
            start = 1'b1;
            waitCycle();
            start = 1'b0;
            while (cyc < d.cyc) waitCycle();
            start = 1'b1;
            waitCycle();
            start = 1'b0;
        end
        guard = 0;
        while (done_q.size() != 0 && guard < 2 * DEPTH + 40) begin
            waitCycle();
            guard++;
        end
        checkOutput("run_done_outstanding", 64'(done_q.size()), 64'd0);
        checkOutput("run_access_outstanding", 64'(acc_q.size()), 64'd0);
        flushQueues();
        repeat (4) waitCycle();
        checkOutput("pass_hold", 64'(pass), 64'(d.pass));
        checkOutput("err_count_hold", 64'(err_count), 64'(d.errc));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_pass"}, 64'(pass), 64'd0);
        checkOutput({tag, "_err_count"}, 64'(err_count), 64'd0);
        checkOutput({tag, "_mem_address"}, 64'(mem_address), 64'd0);
        checkOutput({tag, "_mem_data_in"}, 64'(mem_data_in), 64'd0);
        checkOutput({tag, "_mem_write"}, 64'(mem_write), 64'd0);
        checkOutput({tag, "_mem_select"}, 64'(mem_select), 64'd0);
`ifdef RAM_BIST_ERRLOG_EN
        checkOutput({tag, "_err_addr"}, 64'(err_addr), 64'd0);
        checkOutput({tag, "_err_got"}, 64'(err_got), 64'd0);
`endif
    endtask

    // Run a test with faults, reset during the read of word 12, then run a clean test.
    task automatic resetDuringRead();
        int base;
        for (int k = 0; k < DEPTH; k++) begin
            or_mask[k]  = '0;
            and_mask[k] = '1;
        end
        or_mask[3] = 32'h10;
        waitCycle();
        base = cyc;
        pushAccesses(DEPTH, SEED, 0);
        start = 1'b1;
        waitCycle();
        start = 1'b0;
        while (cyc < base + DEPTH + 1 + 12) waitCycle();
        checkOutput("pre_reset_read_addr", 64'(mem_address), 64'd12);
        checkOutput("pre_reset_read_select", 64'(mem_select), 64'd1);
        checkOutput("pre_reset_read_write", 64'(mem_write), 64'd0);
        checkOutput("pre_reset_err_count", 64'(err_count), 64'd1);
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        flushQueues();
        repeat (2) waitCycle();
        rst_n = 1'b1;
        repeat (2 * DEPTH + 8) waitCycle();
        checkOutput("no_done_after_reset_err_count", 64'(err_count), 64'd0);
        applyStimulus(0, 1'b0, 1'b0);
    endtask

    task automatic runComb(input bit fault);
        done_rec_t d;
        int        base, guard;
        for (int k = 0; k < 4; k++) or_c[k] = '0;
        if (fault) or_c[$urandom_range(0, 3)][$urandom_range(1, DW - 1)] = 1'b1;
        waitCycle();
        base = cyc;
        d = modelRun(4, 7, base, 0, 1'b0, 1'b1);
        pushAccesses(4, 7, 1);
        done_q_c.push_back(d);
        start_c = 1'b1;
        waitCycle();
        start_c = 1'b0;
        guard = 0;
        while (done_q_c.size() != 0 && guard < 40) begin
            waitCycle();
            guard++;
        end
        checkOutput("c_run_done_outstanding", 64'(done_q_c.size()), 64'd0);
        checkOutput("c_run_access_outstanding", 64'(acc_q_c.size()), 64'd0);
        flushQueues();
        repeat (3) waitCycle();
    endtask

    task automatic runStuck();
        done_rec_t d;
        int        base, guard;
        waitCycle();
        base = cyc;
        d = modelRun(8, 0, base, 1, 1'b1, 1'b0);
        pushAccesses(8, 0, 2);
        done_q_w.push_back(d);
        start_w = 1'b1;
        waitCycle();
        start_w = 1'b0;
        guard = 0;
        while (done_q_w.size() != 0 && guard < 60) begin
            waitCycle();
            guard++;
        end
        checkOutput("w_run_done_outstanding", 64'(done_q_w.size()), 64'd0);
        checkOutput("w_run_access_outstanding", 64'(acc_q_w.size()), 64'd0);
        flushQueues();
        repeat (3) waitCycle();
    endtask

    initial begin
        for (int k = 0; k < (1 << AW); k++) begin
            or_mask[k]  = '0;
            and_mask[k] = '1;
            or_c[k]     = '0;
        end
        rst_n = 1'b0;
        repeat (3) waitCycle();
        checkAllZero("reset");
        rst_n = 1'b1;
        repeat (2) waitCycle();

        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            applyStimulus($urandom_range(0, 4), 1'b0, ($urandom_range(0, 1) == 1));
        end
        resetDuringRead();
        runComb(1'b0);
        runComb(1'b1);
        runStuck();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout got=%0t required=finish", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
